// File: rtl/bios_wdt_core.sv
// BIOS watchdog engine: unlock/command sequencer, seconds countdown, expiry reset request.
// Optional pre-timeout warning output enabled by defining BIOS_WDT_PRETIMEOUT_EN.
module bios_wdt_core #(
  parameter int unsigned TIMEOUT_SEC  = 180,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned UNLOCK_WIN   = 16,
  parameter int unsigned RST_PULSE    = 32,
  parameter bit          ARM_AT_RESET = 1'b1,
  parameter int unsigned PRE_SEC      = 10
) (
  input  logic             MainResetN,
  input  logic             CLK32768,
  input  logic [4:0]       bCPUWrWdtRegSig,
  output logic             WdtArmed,
  output logic [CNT_W-1:0] WdtCount,
  output logic             WdtExpired,
  output logic             WdtRstReqN,
  output logic             WdtPreWarn
);

  localparam int unsigned WIN_W = $clog2(UNLOCK_WIN + 1);
  localparam int unsigned PUL_W = $clog2(RST_PULSE + 1);
  localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(TIMEOUT_SEC);
  localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(UNLOCK_WIN);
  localparam logic [PUL_W-1:0] PUL_LOAD = PUL_W'(RST_PULSE);

  typedef enum logic [2:0] {OFF, OFF_UNL, RUN, RUN_UNL, EXP} state_e;
  typedef enum logic [2:0] {CMD_NONE, CMD_UNL, CMD_ARM, CMD_DIS, CMD_KICK, CMD_BAD} cmd_e;

  state_e           state;
  cmd_e             cmd;
  logic [4:0]       s1, s2, s3, ev;
  logic [14:0]      presc;
  logic [WIN_W-1:0] win;
  logic [PUL_W-1:0] pulseCnt;
  logic             inRun, tick1s, winLast, reloadHit, disHit;

  always_ff @(posedge CLK32768 or negedge MainResetN) begin
    if (!MainResetN) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= bCPUWrWdtRegSig;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Each strobe bit toggles once per CPU write; an edge on s2 is one command.
  always_comb begin
    ev  = s2 ^ s3;
    cmd = CMD_NONE;
    case (ev)
      5'b00000: cmd = CMD_NONE;
      5'b00001: cmd = CMD_UNL;
      5'b00010: cmd = CMD_ARM;
      5'b00100: cmd = CMD_DIS;
      5'b01000: cmd = CMD_KICK;
      default:  cmd = CMD_BAD;
    endcase
  end

  always_comb begin
    inRun     = (state == RUN) || (state == RUN_UNL);
    tick1s    = inRun && (presc == '1);
    winLast   = (win <= WIN_W'(1));
    reloadHit = ((state == RUN_UNL) && ((cmd == CMD_KICK) || (cmd == CMD_ARM))) ||
                ((state == OFF_UNL) && (cmd == CMD_ARM));
    disHit    = (state == RUN_UNL) && (cmd == CMD_DIS);
  end

  always_ff @(posedge CLK32768 or negedge MainResetN) begin
    if (!MainResetN) begin
      state      <= ARM_AT_RESET ? RUN : OFF;
      presc      <= '0;
      win        <= '0;
      pulseCnt   <= '0;
      WdtCount   <= RELOAD;
      WdtArmed   <= ARM_AT_RESET;
      WdtExpired <= 1'b0;
      WdtRstReqN <= 1'b1;
    end else begin
      case (state)
        OFF: begin
          if (cmd == CMD_UNL) begin
            state <= OFF_UNL;
            win   <= WIN_LOAD;
          end
        end
        OFF_UNL: begin
          case (cmd)
            CMD_ARM: begin
              state    <= RUN;
              WdtArmed <= 1'b1;
              WdtCount <= RELOAD;
              presc    <= '0;
              win      <= '0;
            end
            CMD_UNL: win <= WIN_LOAD;
            CMD_NONE: begin
              if (winLast) begin
                state <= OFF;
                win   <= '0;
              end else begin
                win <= win - 1'b1;
              end
            end
            default: begin
              state <= OFF;
              win   <= '0;
            end
          endcase
        end
        RUN, RUN_UNL: begin
          // Reloading commands take priority over a same-cycle tick1s.
          if (disHit) begin
            state    <= OFF;
            WdtArmed <= 1'b0;
            WdtCount <= RELOAD;
            presc    <= '0;
            win      <= '0;
          end else if (reloadHit) begin
            state    <= RUN;
            WdtCount <= RELOAD;
            presc    <= '0;
            win      <= '0;
          end else begin
            if (cmd == CMD_UNL) begin
              state <= RUN_UNL;
              win   <= WIN_LOAD;
            end else if ((state == RUN_UNL) &&
                         ((cmd == CMD_BAD) || ((cmd == CMD_NONE) && winLast))) begin
              state <= RUN;
              win   <= '0;
            end else if (state == RUN_UNL) begin
              win <= win - 1'b1;
            end
            presc <= presc + 15'd1;
            if (tick1s) begin
              if (WdtCount == CNT_W'(1)) begin
                state      <= EXP;
                WdtCount   <= '0;
                WdtArmed   <= 1'b0;
                WdtExpired <= 1'b1;
                pulseCnt   <= PUL_LOAD;
                presc      <= '0;
                win        <= '0;
              end else begin
                WdtCount <= WdtCount - 1'b1;
              end
            end
          end
        end
        EXP: begin
          if (pulseCnt != '0) begin
            WdtRstReqN <= 1'b0;
            pulseCnt   <= pulseCnt - 1'b1;
          end else begin
            WdtRstReqN <= 1'b1;
          end
        end
        default: state <= OFF;
      endcase
    end
  end

`ifdef BIOS_WDT_PRETIMEOUT_EN
  always_ff @(posedge CLK32768 or negedge MainResetN) begin
    if (!MainResetN) begin
      WdtPreWarn <= 1'b0;
    end else if (reloadHit || disHit) begin
      WdtPreWarn <= 1'b0;
    end else if (tick1s && (WdtCount == CNT_W'(PRE_SEC + 1))) begin
      WdtPreWarn <= 1'b1;
    end
  end
`else
  assign WdtPreWarn = 1'b0;
`endif

endmodule

// File: tb/tb_bios_wdt_core.sv
// Self-checking bench for bios_wdt_core: three instances against a behavioural model.
module tb_bios_wdt_core;
  localparam int N      = 3;
  localparam int WIN    = 16;
  localparam int PULSE  = 32;
  localparam int PRE    = 10;
  localparam int PER    = 32768;
  localparam int C_NONE = 0, C_UNL = 1, C_ARM = 2, C_DIS = 3, C_KICK = 4, C_BAD = 5;
`ifdef BIOS_WDT_PRETIMEOUT_EN
  localparam bit PW_EN = 1'b1;
`else
  localparam bit PW_EN = 1'b0;
`endif

  logic       clk  = 1'b0;
  logic       rstN = 1'b0;
  logic [4:0] wr [N];
  logic       armed [N];
  logic       expd [N];
  logic       rq [N];
  logic       pw [N];
  logic [7:0] cnt [N];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // dutA: armed at reset, 3 s; dutB: off at reset, 12 s; dutC: armed at reset, 3 s
  bios_wdt_core #(.TIMEOUT_SEC(3), .CNT_W(8), .UNLOCK_WIN(16), .RST_PULSE(32),
                  .ARM_AT_RESET(1'b1), .PRE_SEC(10)) dutA (
    .MainResetN(rstN), .CLK32768(clk), .bCPUWrWdtRegSig(wr[0]), .WdtArmed(armed[0]),
    .WdtCount(cnt[0]), .WdtExpired(expd[0]), .WdtRstReqN(rq[0]), .WdtPreWarn(pw[0]));
  bios_wdt_core #(.TIMEOUT_SEC(12), .CNT_W(8), .UNLOCK_WIN(16), .RST_PULSE(32),
                  .ARM_AT_RESET(1'b0), .PRE_SEC(10)) dutB (
    .MainResetN(rstN), .CLK32768(clk), .bCPUWrWdtRegSig(wr[1]), .WdtArmed(armed[1]),
    .WdtCount(cnt[1]), .WdtExpired(expd[1]), .WdtRstReqN(rq[1]), .WdtPreWarn(pw[1]));
  bios_wdt_core #(.TIMEOUT_SEC(3), .CNT_W(8), .UNLOCK_WIN(16), .RST_PULSE(32),
                  .ARM_AT_RESET(1'b1), .PRE_SEC(10)) dutC (
    .MainResetN(rstN), .CLK32768(clk), .bCPUWrWdtRegSig(wr[2]), .WdtArmed(armed[2]),
    .WdtCount(cnt[2]), .WdtExpired(expd[2]), .WdtRstReqN(rq[2]), .WdtPreWarn(pw[2]));

  function automatic int toOf(int k);
    return (k == 1) ? 12 : 3;
  endfunction

  function automatic bit armOf(int k);
    return (k != 1);
  endfunction

  // Model: unlocked-window remaining, seconds left, phase within the current second.
  typedef struct {
    bit armed, expd, rq, pw;
    int unl, sec, ph, pulse;
    logic [4:0] d1, d2, d3;
  } mdl_t;

  mdl_t m [N];

  function automatic mdl_t mreset(int k);
    mdl_t r;
    r.armed = armOf(k); r.expd = 1'b0; r.rq = 1'b1; r.pw = 1'b0;
    r.unl = 0; r.sec = toOf(k); r.ph = 0; r.pulse = 0;
    r.d1 = '0; r.d2 = '0; r.d3 = '0;
    return r;
  endfunction

  function automatic mdl_t mstep(mdl_t mi, logic [4:0] w, int k);
    mdl_t r;
    logic [4:0] ev;
    int c;
    bit done;
    r = mi;
    ev = r.d2 ^ r.d3;
    r.d3 = r.d2; r.d2 = r.d1; r.d1 = w;
    if (ev == 5'd0)                          c = C_NONE;
    else if ($countones(ev) != 1 || ev[4])   c = C_BAD;
    else if (ev[0])                          c = C_UNL;
    else if (ev[1])                          c = C_ARM;
    else if (ev[2])                          c = C_DIS;
    else                                     c = C_KICK;
    if (r.expd) begin
      if (r.pulse > 0) begin r.rq = 1'b0; r.pulse--; end
      else r.rq = 1'b1;
      return r;
    end
    if (!r.armed) begin
      if (r.unl > 0) begin
        if (c == C_ARM) begin r.armed = 1'b1; r.sec = toOf(k); r.ph = 0; r.unl = 0; r.pw = 1'b0; end
        else if (c == C_UNL) r.unl = WIN;
        else if (c != C_NONE) r.unl = 0;
        else r.unl--;
      end else if (c == C_UNL) r.unl = WIN;
      return r;
    end
    done = 1'b0;
    if (r.unl > 0) begin
      if (c == C_ARM || c == C_KICK) begin
        r.sec = toOf(k); r.ph = 0; r.unl = 0; r.pw = 1'b0; done = 1'b1;
      end else if (c == C_DIS) begin
        r.armed = 1'b0; r.sec = toOf(k); r.ph = 0; r.unl = 0; r.pw = 1'b0; done = 1'b1;
      end else if (c == C_UNL) r.unl = WIN;
      else if (c == C_BAD) r.unl = 0;
      else r.unl--;
    end else if (c == C_UNL) r.unl = WIN;
    if (!done) begin
      if (r.ph == PER - 1) begin
        r.ph = 0;
        if (r.sec == 1) begin
          r.sec = 0; r.expd = 1'b1; r.armed = 1'b0; r.unl = 0; r.pulse = PULSE;
        end else begin
          r.sec--;
          if (PW_EN && r.sec == PRE) r.pw = 1'b1;
        end
      end else r.ph++;
    end
    return r;
  endfunction

  always @(posedge clk or negedge rstN) begin
    for (int k = 0; k < N; k++) begin
      if (!rstN) m[k] <= mreset(k);
      else       m[k] <= mstep(m[k], wr[k], k);
    end
  end

  int cyc;
  always @(posedge clk or negedge rstN) begin
    if (!rstN) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Timestamps of dutA count changes and reset-request edges.
  int         chg[$];
  int         fallCyc = -1;
  int         riseCyc = -1;
  logic [7:0] pc  = 8'd3;
  logic       prq = 1'b1;
  always @(negedge clk) begin
    if (rstN) begin
      if (cnt[0] !== pc) chg.push_back(cyc);
      if (rq[0] === 1'b0 && prq === 1'b1) fallCyc <= cyc;
      if (rq[0] === 1'b1 && prq === 1'b0) riseCyc <= cyc;
      pc  <= cnt[0];
      prq <= rq[0];
    end
  end

  task automatic toggle(input int k, input logic [4:0] mask);
    wr[k] = wr[k] ^ mask;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic test_reset;
    for (int k = 0; k < N; k++) wr[k] = '0;
    rstN = 1'b0;
    cycles(3);
    for (int k = 0; k < N; k++) begin
      checks++;
      if ({armed[k], expd[k], rq[k], pw[k], cnt[k]} !== {armOf(k), 1'b0, 1'b1, 1'b0, 8'(toOf(k))}) begin
        errors++;
        $display("FAIL reset dut%0d got aerp=%b%b%b%b cnt=%0d exp a=%b cnt=%0d",
                 k, armed[k], expd[k], rq[k], pw[k], cnt[k], armOf(k), toOf(k));
      end
    end
    rstN = 1'b1;
  endtask

  task automatic test_unlock_window;
    toggle(1, 5'b00001); cycles(20); toggle(1, 5'b00010); cycles(6);
    checks++;
    if ({armed[1], cnt[1]} !== {1'b0, 8'd12}) begin
      errors++; $display("FAIL win_late got armed=%b cnt=%0d exp armed=0 cnt=12", armed[1], cnt[1]);
    end
    toggle(1, 5'b00001); cycles(4); toggle(1, 5'b00010); cycles(6);
    checks++;
    if ({armed[1], cnt[1]} !== {1'b1, 8'd12}) begin
      errors++; $display("FAIL win_ok got armed=%b cnt=%0d exp armed=1 cnt=12", armed[1], cnt[1]);
    end
  endtask

  task automatic test_run_cmds;
    toggle(1, 5'b00001); cycles(5); toggle(1, 5'b10000); cycles(6);
    checks++;
    if ({armed[1], cnt[1]} !== {1'b1, 8'(m[1].sec)}) begin
      errors++; $display("FAIL run_bad got armed=%b cnt=%0d exp armed=1 cnt=%0d", armed[1], cnt[1], m[1].sec);
    end
    toggle(1, 5'b00001); cycles(5); toggle(1, 5'b00100); cycles(6);
    checks++;
    if ({armed[1], cnt[1]} !== {1'b0, 8'd12}) begin
      errors++; $display("FAIL run_dis got armed=%b cnt=%0d exp armed=0 cnt=12", armed[1], cnt[1]);
    end
  endtask

  task automatic test_same_cycle_bad;
    toggle(1, 5'b00001); cycles(5); toggle(1, 5'b01001); cycles(6);
    toggle(1, 5'b00010); cycles(6);
    checks++;
    if (armed[1] !== 1'b0) begin
      errors++; $display("FAIL bad_off got armed=%b exp 0", armed[1]);
    end
    toggle(1, 5'b00001); cycles(4); toggle(1, 5'b00010); cycles(6);
    toggle(1, 5'b00001); cycles(5); toggle(1, 5'b01001); cycles(6);
    toggle(1, 5'b00100); cycles(6);
    checks++;
    if ({armed[1], cnt[1]} !== {1'b1, 8'd12}) begin
      errors++; $display("FAIL bad_run got armed=%b cnt=%0d exp armed=1 cnt=12", armed[1], cnt[1]);
    end
  endtask

  task automatic test_random;
    int r, b1, b2;
    logic [4:0] mk;
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      checks++;
      if ({armed[1], expd[1], rq[1], pw[1], cnt[1]} !==
          {m[1].armed, m[1].expd, m[1].rq, m[1].pw, 8'(m[1].sec)}) begin
        errors++;
        $display("FAIL rand cyc=%0d got aerp=%b%b%b%b cnt=%0d exp aerp=%b%b%b%b cnt=%0d", cyc,
                 armed[1], expd[1], rq[1], pw[1], cnt[1], m[1].armed, m[1].expd, m[1].rq, m[1].pw, m[1].sec);
      end
      if ($urandom_range(0, 5) == 0) begin
        r = $urandom_range(0, 5);
        if (r < 5) mk = 5'b1 << r;
        else begin
          b1 = $urandom_range(0, 4);
          b2 = (b1 + $urandom_range(1, 4)) % 5;
          mk = (5'b1 << b1) | (5'b1 << b2);
        end
        toggle(1, mk);
      end
    end
    cycles(20);
    toggle(1, 5'b00001); cycles(5); toggle(1, 5'b00100); cycles(6);
    checks++;
    if ({armed[1], cnt[1]} !== {1'b0, 8'd12}) begin
      errors++; $display("FAIL rand_settle got armed=%b cnt=%0d exp armed=0 cnt=12", armed[1], cnt[1]);
    end
  endtask

  task automatic test_pretimeout;
    bit hit = 1'b0;
    toggle(1, 5'b00001); cycles(4); toggle(1, 5'b00010);
    for (int n = 0; n < 2 * PER + 64 && !hit; n++) begin
      @(negedge clk);
      checks++;
      if ({armed[1], expd[1], pw[1], cnt[1]} !== {m[1].armed, m[1].expd, m[1].pw, 8'(m[1].sec)}) begin
        errors++;
        $display("FAIL pre_track cyc=%0d got a=%b e=%b p=%b cnt=%0d exp a=%b e=%b p=%b cnt=%0d", cyc,
                 armed[1], expd[1], pw[1], cnt[1], m[1].armed, m[1].expd, m[1].pw, m[1].sec);
      end
      if (m[1].sec == toOf(1) - 2) hit = 1'b1;
    end
    checks++;
    if (!hit || {pw[1], cnt[1]} !== {PW_EN, 8'd10}) begin
      errors++; $display("FAIL pre_rise hit=%b got pw=%b cnt=%0d exp pw=%b cnt=10", hit, pw[1], cnt[1], PW_EN);
    end
    toggle(1, 5'b00001); cycles(5); toggle(1, 5'b01000); cycles(6);
    checks++;
    if ({pw[1], cnt[1], armed[1]} !== {1'b0, 8'd12, 1'b1}) begin
      errors++; $display("FAIL pre_kick got pw=%b cnt=%0d armed=%b exp pw=0 cnt=12 armed=1", pw[1], cnt[1], armed[1]);
    end
  endtask

  task automatic test_kick_collision;
    checks++;
    if (cyc > 98296) begin
      errors++; $display("FAIL coll_sched got cyc=%0d exp <=98296", cyc);
    end
    wait_cyc(98296);
    checks++;
    if ({cnt[2], expd[2]} !== {8'd1, 1'b0}) begin
      errors++; $display("FAIL coll_pre got cnt=%0d expd=%b exp cnt=1 expd=0", cnt[2], expd[2]);
    end
    toggle(2, 5'b00001);
    wait_cyc(98301);
    toggle(2, 5'b01000);
    wait_cyc(98310);
    checks++;
    if ({cnt[2], expd[2], armed[2], rq[2]} !== {8'd3, 1'b0, 1'b1, 1'b1}) begin
      errors++; $display("FAIL coll_kick got cnt=%0d expd=%b armed=%b rq=%b exp cnt=3 expd=0 armed=1 rq=1",
                         cnt[2], expd[2], armed[2], rq[2]);
    end
    checks++;
    if ({cnt[2], expd[2]} !== {8'(m[2].sec), m[2].expd}) begin
      errors++; $display("FAIL coll_model got cnt=%0d expd=%b exp cnt=%0d expd=%b", cnt[2], expd[2], m[2].sec, m[2].expd);
    end
  endtask

  task automatic test_expiry;
    wait_cyc(98345);
    checks++;
    if (chg.size() != 3) begin
      errors++; $display("FAIL exp_nchg got %0d exp 3", chg.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (chg[i] != (i + 1) * PER) begin
          errors++; $display("FAIL exp_tick%0d got cyc=%0d exp %0d", i, chg[i], (i + 1) * PER);
        end
      end
    end
    checks++;
    if (fallCyc != 3 * PER + 1 || riseCyc != 3 * PER + 1 + PULSE) begin
      errors++; $display("FAIL exp_pulse got fall=%0d rise=%0d exp fall=%0d rise=%0d",
                         fallCyc, riseCyc, 3 * PER + 1, 3 * PER + 1 + PULSE);
    end
    toggle(0, 5'b00001); cycles(4); toggle(0, 5'b00010); cycles(4); toggle(0, 5'b01000); cycles(6);
    checks++;
    if ({expd[0], cnt[0], armed[0], rq[0]} !== {1'b1, 8'd0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL exp_hold got expd=%b cnt=%0d armed=%b rq=%b exp expd=1 cnt=0 armed=0 rq=1",
                         expd[0], cnt[0], armed[0], rq[0]);
    end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    rstN = 1'b0;
    #1;
    for (int k = 0; k < N; k++) begin
      checks++;
      if ({armed[k], expd[k], rq[k], pw[k], cnt[k]} !== {armOf(k), 1'b0, 1'b1, 1'b0, 8'(toOf(k))}) begin
        errors++;
        $display("FAIL async_rst dut%0d got aerp=%b%b%b%b cnt=%0d exp a=%b cnt=%0d",
                 k, armed[k], expd[k], rq[k], pw[k], cnt[k], armOf(k), toOf(k));
      end
    end
  endtask

  initial begin
    test_reset;
    test_unlock_window;
    test_run_cmds;
    test_same_cycle_bad;
    test_random;
    test_pretimeout;
    test_kick_collision;
    test_expiry;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL timeout cyc=%0d exp finish before limit", cyc);
    $fatal(1, "time limit");
  end

endmodule
